// File: rtl/counter_pkg.sv
// Shared definitions for the counter slot arbiter: FSM state encoding and
// the requester-index width helper.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    // Requester index width; never narrower than one bit.
    function automatic int id_width(input int num_req);
        return (num_req < 32'sd2) ? 32'sd1 : $clog2(num_req);
    endfunction

    localparam int DEFAULT_NUM_REQ = 32'sd4;
    localparam int DEFAULT_ID_W    = id_width(DEFAULT_NUM_REQ);

endpackage

// File: rtl/slot_counter.sv
// Elapsed-cycle counter for one arbitration slot. Clear wins over enable,
// and the value saturates at MAX_COUNT instead of wrapping.
module slot_counter #(
    parameter int CNT_W     = 8,
    parameter int MAX_COUNT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Count register: sync active-low reset, clear, saturating increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && (count_r != MAX_C)) begin
            count_r <= count_r + ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/counter_slot_arbiter.sv
// Round-robin slot arbiter: grants one requester a slot of up to
// min(slot_len, MAX_COUNT)+1 cycles, then a one-cycle DONE before re-arbitrating.
module counter_slot_arbiter
    import counter_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  CNT_W     = 8,
    parameter int  MAX_COUNT = 255,
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rel,
    input  logic [CNT_W-1:0]   slot_len,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic [CNT_W-1:0]   count,
    output logic               done
);

    localparam logic [CNT_W-1:0]   MAX_C   = CNT_W'(MAX_COUNT);
    localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W-1:0]    ONE_ID  = ID_W'(1);
    localparam logic [NUM_REQ-1:0] ONE_HOT = NUM_REQ'(1);

    arb_state_e         state_r, state_nxt_s;
    logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
    logic [ID_W-1:0]    grant_id_r, grant_id_nxt_s;
    logic [ID_W-1:0]    ptr_r, ptr_nxt_s;
    logic [CNT_W-1:0]   limit_r, limit_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;

    logic [ID_W-1:0]    winner_s;
    logic [ID_W-1:0]    idx_s;
    logic               found_s;
    logic [CNT_W-1:0]   len_clip_s;
    logic [CNT_W-1:0]   count_s;
    logic               term_s;
    logic               cnt_en_s;
    logic               cnt_clr_s;

    slot_counter #(
        .CNT_W    (CNT_W),
        .MAX_COUNT(MAX_COUNT)
    ) u_slot_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en_s),
        .clr  (cnt_clr_s),
        .count(count_s)
    );

    // Round-robin pick: first requester at or after ptr_r, wrapping around.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        idx_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s    = ID_W'((int'(ptr_r) + k) % NUM_REQ);
            winner_s = (!found_s && req[idx_s]) ? idx_s : winner_s;
            found_s  = found_s | req[idx_s];
        end
    end

    assign len_clip_s = (slot_len > MAX_C) ? MAX_C : slot_len;

    // Next-state and next-output logic; only the owner's req/rel bits matter in RUN.
    always_comb begin
        state_nxt_s    = state_r;
        grant_nxt_s    = grant_r;
        grant_id_nxt_s = grant_id_r;
        ptr_nxt_s      = ptr_r;
        limit_nxt_s    = limit_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        cnt_en_s       = 1'b0;
        cnt_clr_s      = 1'b1;
        term_s         = (count_s == limit_r) || rel[grant_id_r] || !req[grant_id_r];

        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_nxt_s    = ST_RUN;
                    grant_nxt_s    = ONE_HOT << winner_s;
                    grant_id_nxt_s = winner_s;
                    limit_nxt_s    = len_clip_s;
                    busy_nxt_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = '0;
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_RUN: begin
                // Count is frozen on the terminating edge so DONE shows the final value.
                cnt_clr_s = 1'b0;
                if (term_s) begin
                    state_nxt_s = ST_DONE;
                    grant_nxt_s = '0;
                    done_nxt_s  = 1'b1;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
                ptr_nxt_s   = (grant_id_r == LAST_ID) ? '0 : (grant_id_r + ONE_ID);
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = '0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any slot without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            grant_id_r <= '0;
            ptr_r      <= '0;
            limit_r    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            grant_r    <= grant_nxt_s;
            grant_id_r <= grant_id_nxt_s;
            ptr_r      <= ptr_nxt_s;
            limit_r    <= limit_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign grant    = grant_r;
    assign grant_id = grant_id_r;
    assign busy     = busy_r;
    assign count    = count_s;
    assign done     = done_r;

endmodule

// File: tb/tb_counter_slot_arbiter.sv
// Randomized scoreboard bench for counter_slot_arbiter: the driver predicts each
// slot from round-robin/limit rules, a negedge monitor checks what the DUT shows.
module tb_counter_slot_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 8;
    localparam int MAXC = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] rel;
    logic [CW-1:0]   slot_len;
    logic [NREQ-1:0] grant;
    logic [1:0]      grant_id;
    logic            busy;
    logic [CW-1:0]   count;
    logic            done;

    always #5 clk = ~clk;

    counter_slot_arbiter #(
        .NUM_REQ  (NREQ),
        .CNT_W    (CW),
        .MAX_COUNT(MAXC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .slot_len(slot_len),
        .grant   (grant),
        .grant_id(grant_id),
        .busy    (busy),
        .count   (count),
        .done    (done)
    );

    typedef struct {
        int owner;
        int fin;
        int gcyc;
        bit aborted;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   m_ptr  = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        logic [NREQ-1:0] sh;
        for (int k = 0; k < NREQ; k++) begin
            sh = r >> ((p + k) % NREQ);
            if (sh[0]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Monitor: observe DUT outputs mid-cycle and retire scoreboard entries.
    bit tracking  = 1'b0;
    bit prev_done = 1'b0;
    int gcnt = 0;
    int bcnt = 0;
    int own  = 0;

    always @(negedge clk) begin
        int              gi;
        exp_t            e;
        logic [NREQ-1:0] gs;
        if (mon_en) begin
            gi = -1;
            for (int i = 0; i < NREQ; i++) begin
                gs = grant >> i;
                if (gs[0]) gi = i;
            end
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            if (busy) bcnt++;
            else bcnt = 0;
            if (!busy) chk("idle_outputs", 32'({grant, count, done}), 32'd0);
            if (gi >= 0) begin
                if (!tracking) begin
                    tracking = 1'b1;
                    gcnt     = 0;
                    own      = gi;
                    if (sb.size() == 0) chk("grant_expected", 32'd0, 32'd1);
                    else begin
                        chk("grant_owner", gi, sb[0].owner);
                        chk("grant_latency", cyc, sb[0].gcyc);
                    end
                end
                chk("grant_stable", gi, own);
                chk("run_count", 32'(count), gcnt);
                chk("run_grant_id", 32'(grant_id), gi);
                chk("run_busy", 32'(busy), 32'd1);
                gcnt++;
            end
            if (done) begin
                chk("done_single", 32'(prev_done), 32'd0);
                if (sb.size() == 0) chk("done_expected", 32'd0, 32'd1);
                else begin
                    e = sb.pop_front();
                    chk("done_not_abort", 32'(e.aborted), 32'd0);
                    chk("done_grant_id", 32'(grant_id), e.owner);
                    chk("done_count", 32'(count), e.fin);
                    chk("grant_cycles", gcnt, e.fin + 1);
                    chk("busy_cycles", bcnt, e.fin + 2);
                    chk("done_grant_clear", 32'(grant), 32'd0);
                end
                tracking = 1'b0;
            end
            if (!rst && tracking) begin
                if (sb.size() == 0) chk("abort_expected", 32'd0, 32'd1);
                else begin
                    e = sb.pop_front();
                    chk("abort_expected", 32'(e.aborted), 32'd1);
                end
                tracking = 1'b0;
            end
            prev_done = done;
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req      = '0;
            rel      = 4'($urandom);
            slot_len = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // kind: 0 runs to limit, 1 owner release, 2 owner drops req, 3 reset abort.
    task automatic run_slot(input logic [NREQ-1:0] pat, input int len, input int kind, input int term_at);
        int              owner;
        int              lim;
        int              fin;
        logic [NREQ-1:0] ob;
        exp_t            e;
        owner = rr_pick(pat, m_ptr);
        lim   = (len > MAXC) ? MAXC : len;
        fin   = lim;
        if (kind != 0 && term_at < lim) fin = term_at;
        ob        = 4'b0001 << owner;
        e.owner   = owner;
        e.fin     = fin;
        e.gcyc    = cyc + 1;
        e.aborted = (kind == 3);
        sb.push_back(e);
        req      = pat;
        rel      = '0;
        slot_len = CW'(len);
        @(posedge clk); #1;
        for (int c = 0; c <= fin; c++) begin
            rel      = 4'($urandom) & ~ob;
            req      = 4'($urandom) | ob;
            slot_len = 8'($urandom);
            if (c == fin) begin
                if (kind == 1) rel = rel | ob;
                else if (kind == 2) req = req & ~ob;
                else if (kind == 3) rst = 1'b0;
            end
            @(posedge clk); #1;
        end
        req = '0;
        rel = '0;
        if (kind == 3) begin
            rst = 1'b1;
            chk("abort_outputs", 32'({grant, grant_id, busy, count, done}), 32'd0);
            m_ptr = 0;
        end else begin
            m_ptr = (owner + 1) % NREQ;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int pat;
        int len;
        int kind;
        int term;
        rst      = 1'b0;
        req      = '0;
        rel      = '0;
        slot_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({grant, grant_id, busy, count, done}), 32'd0);
        rst    = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_after_reset", 32'({grant, grant_id, busy, count, done}), 32'd0);
        end

        repeat (5) run_slot(4'b1111, 0, 0, 0);
        run_slot(4'b0001, 3, 0, 0);
        run_slot(4'b0100, 200, 1, 5);
        run_slot(4'b1000, 255, 0, 0);
        run_slot(4'b0001, 20, 3, 7);
        run_slot(4'b0110, 4, 0, 0);
        run_slot(4'b1010, 6, 2, 2);

        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            pat  = $urandom_range(1, 15);
            len  = ($urandom_range(0, 3) == 3) ? $urandom_range(0, 255) : $urandom_range(0, 14);
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 24) == 0) kind = 3;
            term = $urandom_range(0, 12);
            run_slot(4'(pat), len, kind, term);
        end

        idle_cycles(3);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/counter_slot_arbiter.md
COUNTER_SLOT_ARBITER -- requirements
Module: counter_slot_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter CNT_W, default 8: counter width.
REQ-003 Parameter MAX_COUNT, default 255: hard ceiling on slot length; SHALL be ≤ 2^CNT_W-1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset; asserted when 0 at a rising clk edge.
REQ-006 req  input  NUM_REQ  per-requester slot request, level-sensitive.
REQ-007 rel  input  NUM_REQ  per-requester early release; only the current owner's bit has effect.
REQ-008 slot_len  input  CNT_W  requested slot length, in cycles minus one; sampled at grant.
REQ-009 grant  output  NUM_REQ  one-hot owner indication; all zero when not in RUN.
REQ-010 grant_id  output  clog2(NUM_REQ)  index of current or last owner.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 count  output  CNT_W  shared counter value, elapsed cycles of current slot.
REQ-013 done  output  1  single-cycle pulse marking slot end.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE: if any req bit is high, select a winner by round-robin starting at pointer ptr, then on the next edge enter RUN with grant[winner]=1, grant_id=winner, count=0, and limit latched as min(slot_len, MAX_COUNT).
REQ-016 IDLE with req==0: remain in IDLE, count held at 0.
REQ-017 RUN: count SHALL increment by 1 each cycle; no wrap inside a slot.
REQ-018 RUN terminates on the edge where count==limit, rel[owner]==1, or req[owner]==0; next state DONE, grant cleared, count held at its final value.
REQ-019 slot_len=0: grant is held exactly 1 cycle.
REQ-020 Simultaneous termination causes are a single termination; only one done pulse SHALL occur.
REQ-021 DONE lasts exactly 1 cycle with done=1, then IDLE; ptr SHALL become (owner+1) mod NUM_REQ, and count SHALL return to 0.
REQ-022 Grant latency SHALL be 1 cycle from req sampled high in IDLE; minimum gap between consecutive grants SHALL be 2 cycles (DONE, IDLE).
REQ-023 rel and req changes of non-owners SHALL NOT affect RUN.
REQ-024 slot_len changes after grant SHALL NOT affect the latched limit.

Reset
REQ-025 On rst==0: state IDLE, grant=0, grant_id=0, busy=0, count=0, done=0, ptr=0, limit=0.
REQ-026 Reset mid-RUN SHALL abort the slot with no done pulse; the first grant after reset starts at ptr=0.

Structure
REQ-027 The state enum and the clog2-derived ID width SHALL live in the shared package counter_pkg.
REQ-028 The counter SHALL be a sub-module slot_counter (ports clk, rst, en, clr, count; parameters CNT_W, MAX_COUNT) that saturates at MAX_COUNT; the arbiter drives en and clr.
REQ-029 The round-robin selector is combinational inside counter_slot_arbiter; no other sub-modules.

Verification
REQ-030 Reset release, req=4'b0000 for 10 cycles -> all outputs 0, state IDLE.
REQ-031 req=4'b0001, slot_len=3 -> grant=0001 one cycle later for 4 cycles with count 0,1,2,3; done pulse; busy for 5 cycles.
REQ-032 req=4'b1111 held, slot_len=0 -> grants rotate 0001,0010,0100,1000,0001, each 1 cycle, spaced 3 cycles apart.
REQ-033 Owner 2 granted with slot_len=200; rel[2]=1 at count=5 -> grant drops next edge, count frozen at 5, done=1 for one cycle.
REQ-034 MAX_COUNT=10, slot_len=255 -> slot ends at count=10 (11 grant cycles).
REQ-035 rst=0 during RUN at count=7 -> next cycle all outputs 0, no done pulse; with req=4'b0110 the next grant is 0010.
